// File: rtl/avalon_mm_simple_master.sv
// Single-outstanding Avalon-MM master. It accepts one request at a time on a
// valid/ready port, runs the matching read or write cycle toward a slave with
// fixed read latency and optional waitrequest, and returns one response pulse.
// All Avalon and response outputs come straight from flops, so nothing on the
// avm_* inputs reaches an output within the same cycle.
module avalon_mm_simple_master #(
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_byteen,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    LAT  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Limits folded to the widths of the counters they are compared against.
  localparam logic [8:0] TMO_LIM = 9'(TIMEOUT);
  localparam logic [2:0] RL_LOAD = 3'(READ_LATENCY);

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [7:0]          tmo_q, tmo_d;
  logic [2:0]          lat_q, lat_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                ready_q, ready_d;
  logic                cs_q, cs_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;

  // Values handed to the response registers on the edge that enters DONE.
  logic [31:0]         cap_data;
  logic                cap_err;
  logic [8:0]          tmo_inc;

  // Next-state logic; output registers are loaded from the state being entered
  // so every strobe lines up exactly with the cycles spent in that state.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    tmo_d    = tmo_q;
    lat_d    = lat_q;
    cap_data = 32'd0;
    cap_err  = 1'b0;
    tmo_inc  = {1'b0, tmo_q} + 9'd1;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_byteen;
          tmo_d   = 8'd0;
          state_d = CMD;
        end
      end
      CMD: begin
        if (avm_waitrequest) begin
          tmo_d = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
          if ((TIMEOUT != 0) && (tmo_inc >= TMO_LIM)) begin
            cap_err = 1'b1;
            state_d = DONE;
          end
        end else if (write_q) begin
          state_d = DONE;
        end else if (READ_LATENCY == 0) begin
          cap_data = avm_readdata;
          state_d  = DONE;
        end else begin
          lat_d   = RL_LOAD;
          state_d = LAT;
        end
      end
      LAT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          cap_data = avm_readdata;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Response fields only change when a new response is produced.
    rdata_d     = (state_d == DONE) ? cap_data : rdata_q;
    err_d       = (state_d == DONE) ? cap_err  : err_q;
    rsp_valid_d = (state_d == DONE);
    ready_d     = (state_d == IDLE);
    cs_d        = (state_d == CMD);
    rd_d        = (state_d == CMD) && !write_d;
    wr_d        = (state_d == CMD) && write_d;
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      tmo_q       <= 8'd0;
      lat_q       <= 3'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      cs_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      tmo_q       <= tmo_d;
      lat_q       <= lat_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
    end
  end

  assign req_ready      = ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_err        = err_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = be_q;
  assign avm_writedata  = wdata_q;
  assign avm_chipselect = cs_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;

endmodule

// File: tb/tb_avalon_mm_simple_master.sv
// Bench for avalon_mm_simple_master: three instances (latency 1 / 0 / 3, the
// latency-0 one with a short timeout), each attached to a blockram-like slave
// whose waitrequest is held for a programmable number of command cycles.
module tb_avalon_mm_simple_master;

  logic        clk;
  logic        reset_n;
  logic        rv   [3];
  logic        rw   [3];
  logic [7:0]  ra   [3];
  logic [31:0] rwd  [3];
  logic [3:0]  rbe  [3];
  logic        rr   [3];
  logic        rsv  [3];
  logic [31:0] rsd  [3];
  logic        rse  [3];
  logic [7:0]  aa   [3];
  logic [3:0]  abe  [3];
  logic        acs  [3];
  logic        ard  [3];
  logic        awr  [3];
  logic [31:0] awd  [3];
  logic [31:0] ardd [3];
  logic        awq  [3];
  int unsigned stall_cfg [3];

  int checks;
  int errors;
  logic [31:0] refmem [3][256];
  logic [31:0] last_data;
  logic        last_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int RL = (g == 1) ? 0 : ((g == 2) ? 3 : 1);
    localparam int TO = (g == 1) ? 4 : 255;
    logic [31:0] mem [256];
    logic [31:0] sr  [8];
    int unsigned cs_cnt;

    avalon_mm_simple_master #(.ADDR_W(8), .READ_LATENCY(RL), .TIMEOUT(TO)) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req_valid      (rv[g]),
      .req_ready      (rr[g]),
      .req_write      (rw[g]),
      .req_addr       (ra[g]),
      .req_wdata      (rwd[g]),
      .req_byteen     (rbe[g]),
      .rsp_valid      (rsv[g]),
      .rsp_rdata      (rsd[g]),
      .rsp_err        (rse[g]),
      .avm_address    (aa[g]),
      .avm_byteenable (abe[g]),
      .avm_chipselect (acs[g]),
      .avm_read       (ard[g]),
      .avm_write      (awr[g]),
      .avm_writedata  (awd[g]),
      .avm_readdata   (ardd[g]),
      .avm_waitrequest(awq[g])
    );

    // Slave stalls the first stall_cfg command cycles of each chipselect burst.
    assign awq[g] = (cs_cnt < stall_cfg[g]);

    // Slave memory and read pipeline; junk fills the pipe on idle cycles.
    always @(posedge clk) begin
      cs_cnt <= acs[g] ? cs_cnt + 1 : 0;
      if (acs[g] && awr[g] && !awq[g]) begin
        for (int b = 0; b < 4; b++)
          if (abe[g][b]) mem[aa[g]][8*b +: 8] <= awd[g][8*b +: 8];
      end
      sr[0] <= (acs[g] && ard[g] && !awq[g]) ? mem[aa[g]] : $urandom;
      for (int j = 1; j < 8; j++) sr[j] <= sr[j-1];
    end

    if (RL == 0) begin : g_rl0
      assign ardd[g] = mem[aa[g]];
    end else begin : g_rln
      assign ardd[g] = sr[RL-1];
    end
  end

  function automatic int rl_of(input int i);
    return (i == 1) ? 0 : ((i == 2) ? 3 : 1);
  endfunction

  function automatic int to_of(input int i);
    return (i == 1) ? 4 : 255;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on instance i with s stalled command cycles; checks timing,
  // strobes, response contents and the one-cycle pulse against the model.
  task automatic txn(input int i, input bit w, input logic [7:0] a,
                     input logic [31:0] d, input logic [3:0] be, input int unsigned s);
    int edges;
    int strobes;
    bit bad;
    bit got;
    bit exp_err;
    int exp_edges;
    int exp_strobes;
    logic [31:0] exp_d;

    exp_err     = (to_of(i) != 0) && (s >= to_of(i));
    exp_strobes = exp_err ? to_of(i) : int'(s) + 1;
    exp_edges   = exp_err ? 1 + to_of(i) : 2 + int'(s) + (w ? 0 : rl_of(i));
    exp_d       = (exp_err || w) ? 32'd0 : refmem[i][a];
    if (w && !exp_err)
      for (int b = 0; b < 4; b++)
        if (be[b]) refmem[i][a][8*b +: 8] = d[8*b +: 8];

    @(negedge clk);
    chk($sformatf("i%0d ready_before", i), 32'(rr[i]), 32'd1);
    stall_cfg[i] = s;
    rv[i] = 1'b1; rw[i] = w; ra[i] = a; rwd[i] = d; rbe[i] = be;
    edges = 0; strobes = 0; bad = 1'b0; got = 1'b0;
    @(posedge clk);
    edges = 1;
    #1;
    // Scramble the request fields: only the accept edge may sample them.
    rv[i] = 1'b0; rw[i] = ~w; ra[i] = ~a; rwd[i] = $urandom; rbe[i] = ~be;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rsv[i]) begin
        got = 1'b1;
        break;
      end
      if (acs[i]) begin
        strobes++;
        if (aa[i] !== a || abe[i] !== be || ard[i] !== !w || awr[i] !== w ||
            (w && awd[i] !== d))
          bad = 1'b1;
      end else if (ard[i] || awr[i]) begin
        bad = 1'b1;
      end
      @(posedge clk);
      edges++;
    end
    chk($sformatf("i%0d rsp_seen", i), 32'(got), 32'd1);
    chk($sformatf("i%0d edges", i), 32'(edges), 32'(exp_edges));
    chk($sformatf("i%0d strobe_cycles", i), 32'(strobes), 32'(exp_strobes));
    chk($sformatf("i%0d cmd_fields_bad", i), 32'(bad), 32'd0);
    chk($sformatf("i%0d rdata", i), rsd[i], exp_d);
    chk($sformatf("i%0d err", i), 32'(rse[i]), 32'(exp_err));
    last_data = rsd[i];
    last_err  = rse[i];
    stall_cfg[i] = 0;
    @(negedge clk);
    chk($sformatf("i%0d pulse_end", i), 32'(rsv[i]), 32'd0);
    chk($sformatf("i%0d ready_after", i), 32'(rr[i]), 32'd1);
    chk($sformatf("i%0d rdata_hold", i), rsd[i], exp_d);
    chk($sformatf("i%0d err_hold", i), 32'(rse[i]), 32'(exp_err));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 8'd0; rwd[i] = 32'd0; rbe[i] = 4'd0;
      stall_cfg[i] = 0;
      for (int k = 0; k < 256; k++) refmem[i][k] = 32'd0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i%0d rst_ready", i), 32'(rr[i]), 32'd1);
      chk($sformatf("i%0d rst_rsp_valid", i), 32'(rsv[i]), 32'd0);
      chk($sformatf("i%0d rst_strobes", i), {29'd0, acs[i], ard[i], awr[i]}, 32'd0);
      chk($sformatf("i%0d rst_rdata", i), rsd[i], 32'd0);
      chk($sformatf("i%0d rst_addr", i), 32'(aa[i]), 32'd0);
    end
    reset_n = 1'b1;

    // Write then read back through the latency-1 blockram.
    txn(0, 1'b1, 8'h12, 32'hDEADBEEF, 4'hF, 0);
    txn(0, 1'b0, 8'h12, 32'd0, 4'hF, 0);
    chk("plan_wr_rd", last_data, 32'hDEADBEEF);

    // Partial byte-enable write.
    txn(0, 1'b1, 8'h20, 32'h11223344, 4'hF, 0);
    txn(0, 1'b1, 8'h20, 32'hAABBCCDD, 4'h5, 0);
    txn(0, 1'b0, 8'h20, 32'd0, 4'hF, 0);
    chk("plan_byteen", last_data, 32'h11BB33DD);

    // Five waitrequest cycles on a read.
    txn(0, 1'b0, 8'h12, 32'd0, 4'hF, 5);
    chk("plan_stall_data", last_data, 32'hDEADBEEF);

    // Timeout after four stalled cycles, then normal traffic resumes.
    txn(1, 1'b1, 8'h30, 32'h12345678, 4'hF, 1000);
    chk("plan_tmo_err", 32'(last_err), 32'd1);
    txn(1, 1'b0, 8'h30, 32'd0, 4'hF, 1000);
    txn(1, 1'b1, 8'h30, 32'hCAFEF00D, 4'hF, 0);
    txn(1, 1'b0, 8'h30, 32'd0, 4'hF, 3);
    chk("plan_after_tmo", last_data, 32'hCAFEF00D);

    // Latency 0 and 3 reads.
    txn(1, 1'b0, 8'h30, 32'd0, 4'hF, 0);
    txn(2, 1'b1, 8'h44, 32'h0BADC0DE, 4'hF, 0);
    txn(2, 1'b0, 8'h44, 32'd0, 4'hF, 0);
    chk("plan_rl3_data", last_data, 32'h0BADC0DE);

    // Randomized traffic on every instance.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 8; k++) txn(i, 1'b1, 8'(k), $urandom, 4'hF, 0);
      for (int k = 0; k < 16; k++)
        txn(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom,
            4'($urandom_range(0, 15)), $urandom_range(0, (i == 1) ? 5 : 3));
    end

    // Asynchronous reset while the latency-3 instance sits in its latency wait.
    @(negedge clk);
    rv[2] = 1'b1; rw[2] = 1'b0; ra[2] = 8'h44; rbe[2] = 4'hF;
    @(posedge clk);
    #1 rv[2] = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_strobes", {29'd0, acs[2], ard[2], awr[2]}, 32'd0);
    chk("arst_rsp_valid", 32'(rsv[2]), 32'd0);
    chk("arst_ready", 32'(rr[2]), 32'd1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("arst_no_rsp", 32'(rsv[2]), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_ready_after", 32'(rr[2]), 32'd1);
    txn(2, 1'b0, 8'h44, 32'd0, 4'hF, 0);
    chk("arst_fresh_read", last_data, 32'h0BADC0DE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
